vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_axis_counter.sv | 63 ++++++
 rtl/vga_timing_gen.sv | 154 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared timing constants for the VGA timing generator.
//   - axis_timing_t : visible / front porch / sync / back porch / sync polarity
//                     for one axis (pixels for H, lines for V).
//   - Preset sets   : 800x600@72 (generator defaults), 640x480@60, 1024x768@60.
//   - axis_total()  : total period of one axis.
// Presets are meant for parameter overrides at instantiation, e.g.
//   .H_VISIBLE(VGA_640X480_60_H.visible), .H_POL(VGA_640X480_60_H.pol), ...
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef struct packed {
        int unsigned visible;
        int unsigned front;
        int unsigned sync;
        int unsigned back;
        logic        pol;     // asserted level of the sync pulse
    } axis_timing_t;

    // 800x600 @ 72 Hz, 50 MHz pixel clock (generator defaults)
    localparam axis_timing_t SVGA_800X600_72_H =
        '{visible: 800, front: 56, sync: 120, back: 64, pol: 1'b1};
    localparam axis_timing_t SVGA_800X600_72_V =
        '{visible: 600, front: 37, sync: 6, back: 23, pol: 1'b1};

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam axis_timing_t VGA_640X480_60_H =
        '{visible: 640, front: 16, sync: 96, back: 48, pol: 1'b0};
    localparam axis_timing_t VGA_640X480_60_V =
        '{visible: 480, front: 10, sync: 2, back: 33, pol: 1'b0};

    // 1024x768 @ 60 Hz, 65 MHz pixel clock, negative syncs
    localparam axis_timing_t XGA_1024X768_60_H =
        '{visible: 1024, front: 24, sync: 136, back: 160, pol: 1'b0};
    localparam axis_timing_t XGA_1024X768_60_V =
        '{visible: 768, front: 3, sync: 6, back: 29, pol: 1'b0};

    // Wide enough for every preset above (largest total is 1344).
    localparam int DEFAULT_CW = 11;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical): a modulo-TOTAL counter plus the
// decodes derived from its current value.
// Ports:
//   clock      in  : system clock
//   rst        in  : asynchronous active-low reset (count -> 0)
//   advance    in  : count steps by one on this cycle
//   count      out : current position, 0 .. TOTAL-1
//   wrap       out : advance is high and count is at TOTAL-1 (steps to 0 now)
//   in_visible out : count < VISIBLE
//   sync       out : POL while count is inside the sync interval, ~POL elsewhere
// Decodes are combinational from count; the top registers them.
// -----------------------------------------------------------------------------
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int VISIBLE = 800,
    parameter int FRONT   = 56,
    parameter int SYNC    = 120,
    parameter int BACK    = 64,
    parameter bit POL     = 1'b1,
    parameter int CW      = DEFAULT_CW
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          advance,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          in_visible,
    output logic          sync
);

    localparam int            TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] VIS_END    = CW'(VISIBLE);
    // Inclusive bounds so a zero back porch cannot overflow CW bits.
    localparam logic [CW-1:0] SYNC_FIRST = CW'(VISIBLE + FRONT);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(VISIBLE + FRONT + SYNC - 1);

    logic [CW-1:0] count_reg;
    logic          at_last;

    assign at_last = (count_reg == LAST);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (advance) begin
            if (at_last) begin
                count_reg <= '0;
            end else begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign count      = count_reg;
    assign wrap       = advance & at_last;
    assign in_visible = (count_reg < VIS_END);
    assign sync       = ((count_reg >= SYNC_FIRST) && (count_reg <= SYNC_LAST)) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// VGA raster timing generator. A horizontal axis counter advances on every
// pixel-clock-enable cycle; the vertical axis counter advances when the
// horizontal one wraps. All outputs are registered from the counter state of
// the same pix_ce cycle, so they trail the counters by one clock and never
// depend combinationally on pix_ce.
// Ports:
//   clock        in  : system clock
//   rst          in  : asynchronous active-low reset
//   pix_ce       in  : pixel clock enable; nothing advances while low
//   h_sync       out : horizontal sync at H_POL
//   v_sync       out : vertical sync at V_POL (changes only with h = 0)
//   active_zone  out : pixel inside the visible area
//   x_pos, y_pos out : visible column / row, forced to 0 outside the visible area
//   line_start   out : one-clock pulse for h = 0
//   frame_start  out : one-clock pulse for h = 0, v = 0
//   frame_count  out : 8-bit frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = int'(SVGA_800X600_72_H.visible),
    parameter int H_FRONT   = int'(SVGA_800X600_72_H.front),
    parameter int H_SYNC    = int'(SVGA_800X600_72_H.sync),
    parameter int H_BACK    = int'(SVGA_800X600_72_H.back),
    parameter int V_VISIBLE = int'(SVGA_800X600_72_V.visible),
    parameter int V_FRONT   = int'(SVGA_800X600_72_V.front),
    parameter int V_SYNC    = int'(SVGA_800X600_72_V.sync),
    parameter int V_BACK    = int'(SVGA_800X600_72_V.back),
    parameter bit H_POL     = SVGA_800X600_72_H.pol,
    parameter bit V_POL     = SVGA_800X600_72_V.pol,
    parameter int CW        = DEFAULT_CW
) (
    input  logic          clock,
    input  logic          rst,
    input  logic          pix_ce,
    output logic          h_sync,
    output logic          v_sync,
    output logic          active_zone,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_count
);

    logic [CW-1:0] h_count;
    logic          h_wrap;
    logic          h_vis;
    logic          h_sync_raw;

    logic [CW-1:0] v_count;
    logic          v_wrap;
    logic          v_vis;
    logic          v_sync_raw;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (H_POL),
        .CW      (CW)
    ) u_h_axis (
        .clock      (clock),
        .rst        (rst),
        .advance    (pix_ce),
        .count      (h_count),
        .wrap       (h_wrap),
        .in_visible (h_vis),
        .sync       (h_sync_raw)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (V_POL),
        .CW      (CW)
    ) u_v_axis (
        .clock      (clock),
        .rst        (rst),
        .advance    (h_wrap),
        .count      (v_count),
        .wrap       (v_wrap),
        .in_visible (v_vis),
        .sync       (v_sync_raw)
    );

    logic          visible;
    logic          at_line_origin;
    logic          at_frame_origin;

    assign visible         = h_vis & v_vis;
    assign at_line_origin  = (h_count == '0);
    assign at_frame_origin = at_line_origin & (v_count == '0);

    logic          h_sync_reg;
    logic          v_sync_reg;
    logic          active_zone_reg;
    logic [CW-1:0] x_pos_reg;
    logic [CW-1:0] y_pos_reg;
    logic          line_start_reg;
    logic          frame_start_reg;
    logic [7:0]    frame_count_reg;
    // Set once a whole frame has elapsed since reset. The first frame_start
    // after reset leaves frame_count at 0; every later one counts a completed
    // frame.
    logic          frame_done_reg;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            h_sync_reg      <= ~H_POL;
            v_sync_reg      <= ~V_POL;
            active_zone_reg <= 1'b0;
            x_pos_reg       <= '0;
            y_pos_reg       <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            frame_count_reg <= 8'd0;
            frame_done_reg  <= 1'b0;
        end else if (pix_ce) begin
            h_sync_reg      <= h_sync_raw;
            v_sync_reg      <= v_sync_raw;
            active_zone_reg <= visible;
            x_pos_reg       <= visible ? h_count : '0;
            y_pos_reg       <= visible ? v_count : '0;
            line_start_reg  <= at_line_origin;
            frame_start_reg <= at_frame_origin;
            if (at_frame_origin && frame_done_reg) begin
                frame_count_reg <= frame_count_reg + 8'd1;
            end
            if (v_wrap) begin
                frame_done_reg <= 1'b1;
            end
        end else begin
            // Stalled pixel: levels hold, pulses must not stretch.
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end
    end

    assign h_sync      = h_sync_reg;
    assign v_sync      = v_sync_reg;
    assign active_zone = active_zone_reg;
    assign x_pos       = x_pos_reg;
    assign y_pos       = y_pos_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generators share clock, reset and pix_ce: one with the 800x600 defaults
// and one with a tiny 4/1/2/1 x 3/1/1/1 raster (H_POL = 0). Each driven cycle
// pushes the expected outputs of a behavioural raster model into a per-DUT
// queue; after the clock edge the entry is popped and compared. Scenario tasks
// add measurements of periods, pulse widths and counter values.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CW = 11;

    localparam int DHV = 800, DHF = 56, DHS = 120, DHB = 64;
    localparam int DVV = 600, DVF = 37, DVS = 6,   DVB = 23;
    localparam int SHV = 4,   SHF = 1,  SHS = 2,   SHB = 1;
    localparam int SVV = 3,   SVF = 1,  SVS = 1,   SVB = 1;

    logic clock = 1'b0;
    logic rst;
    logic pix_ce;

    always #5 clock = ~clock;

    logic          d_hs, d_vs, d_az, d_ls, d_fs;
    logic [CW-1:0] d_x, d_y;
    logic [7:0]    d_fc;
    logic          s_hs, s_vs, s_az, s_ls, s_fs;
    logic [CW-1:0] s_x, s_y;
    logic [7:0]    s_fc;

    vga_timing_gen dut_def (
        .clock       (clock),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .h_sync      (d_hs),
        .v_sync      (d_vs),
        .active_zone (d_az),
        .x_pos       (d_x),
        .y_pos       (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs),
        .frame_count (d_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE (SHV), .H_FRONT (SHF), .H_SYNC (SHS), .H_BACK (SHB),
        .V_VISIBLE (SVV), .V_FRONT (SVF), .V_SYNC (SVS), .V_BACK (SVB),
        .H_POL     (1'b0), .V_POL   (1'b1), .CW    (CW)
    ) dut_small (
        .clock       (clock),
        .rst         (rst),
        .pix_ce      (pix_ce),
        .h_sync      (s_hs),
        .v_sync      (s_vs),
        .active_zone (s_az),
        .x_pos       (s_x),
        .y_pos       (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs),
        .frame_count (s_fc)
    );

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          az;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
        logic [7:0]    fc;
    } outs_t;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        started;   // a frame_start has been seen since reset
        outs_t       o;         // output registers as they should read
    } model_t;

    model_t m_def, m_small;
    outs_t  q_def[$];
    outs_t  q_small[$];
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;

    function automatic model_t model_reset(input bit hpol, input bit vpol);
        model_t r;
        r      = '0;
        r.o.hs = ~hpol;
        r.o.vs = ~vpol;
        return r;
    endfunction

    // Raster behaviour from the timing description: outputs describe the
    // (h, v) position the pixel enable consumed, then the position advances.
    function automatic model_t model_step(input model_t m, input bit ce,
                                          input int hv, input int hf, input int hsw, input int hb,
                                          input int vv, input int vf, input int vsw, input int vb,
                                          input bit hpol, input bit vpol);
        model_t n;
        int h, v, ht, vt;
        n  = m;
        h  = int'(m.h);
        v  = int'(m.v);
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (ce) begin
            n.o.az = (h < hv) && (v < vv);
            n.o.x  = n.o.az ? CW'(h) : '0;
            n.o.y  = n.o.az ? CW'(v) : '0;
            n.o.hs = (h >= hv + hf && h < hv + hf + hsw) ? hpol : ~hpol;
            n.o.vs = (v >= vv + vf && v < vv + vf + vsw) ? vpol : ~vpol;
            n.o.ls = (h == 0);
            n.o.fs = (h == 0) && (v == 0);
            if (n.o.fs) begin
                if (m.started) n.o.fc = m.o.fc + 8'd1;
                n.started = 1'b1;
            end
            if (h == ht - 1) begin
                n.h = '0;
                n.v = (v == vt - 1) ? 16'd0 : 16'(v + 1);
            end else begin
                n.h = 16'(h + 1);
            end
        end else begin
            n.o.ls = 1'b0;
            n.o.fs = 1'b0;
        end
        return n;
    endfunction

    function automatic string fmt(input outs_t o);
        return $sformatf("hs=%b vs=%b az=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                         o.hs, o.vs, o.az, o.x, o.y, o.ls, o.fs, o.fc);
    endfunction

    // One clock: drive pix_ce, push the expected outputs, pop and compare
    // after the edge. Called at a falling edge, returns at the next one.
    task automatic tick(input bit ce);
        outs_t exp_d, exp_s, got_d, got_s;
        pix_ce  = ce;
        m_def   = model_step(m_def, ce, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, 1'b1, 1'b1);
        m_small = model_step(m_small, ce, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0, 1'b1);
        q_def.push_back(m_def.o);
        q_small.push_back(m_small.o);
        @(posedge clock);
        #1;
        cyc++;
        got_d = {d_hs, d_vs, d_az, d_x, d_y, d_ls, d_fs, d_fc};
        got_s = {s_hs, s_vs, s_az, s_x, s_y, s_ls, s_fs, s_fc};
        exp_d = q_def.pop_front();
        exp_s = q_small.pop_front();
        tests_run++;
        if (got_d !== exp_d) begin
            tests_failed++;
            $display("FAIL sb_default cyc=%0d got {%s} expected {%s}", cyc, fmt(got_d), fmt(exp_d));
        end
        tests_run++;
        if (got_s !== exp_s) begin
            tests_failed++;
            $display("FAIL sb_small cyc=%0d got {%s} expected {%s}", cyc, fmt(got_s), fmt(exp_s));
        end
        @(negedge clock);
    endtask

    // Stimulus only: pulse reset across one rising edge with pix_ce low.
    task automatic apply_reset();
        pix_ce  = 1'b0;
        rst     = 1'b0;
        m_def   = model_reset(1'b1, 1'b1);
        m_small = model_reset(1'b0, 1'b1);
        @(negedge clock);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        outs_t got, exp_v;
        @(negedge clock);
        m_def   = model_reset(1'b1, 1'b1);
        m_small = model_reset(1'b0, 1'b1);
        got   = {d_hs, d_vs, d_az, d_x, d_y, d_ls, d_fs, d_fc};
        exp_v = m_def.o;
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_default got {%s} expected {%s}", fmt(got), fmt(exp_v));
        end
        got   = {s_hs, s_vs, s_az, s_x, s_y, s_ls, s_fs, s_fc};
        exp_v = m_small.o;
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_small got {%s} expected {%s}", fmt(got), fmt(exp_v));
        end
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        $display("[TB] test_reset done at cycle %0d", cyc);
    endtask

    task automatic test_first_pixel();
        tick(1'b1);
        tests_run++;
        if ({d_az, d_ls, d_fs, d_x, d_fc} !== {3'b111, 11'd0, 8'd0}) begin
            tests_failed++;
            $display("FAIL first_pixel got az=%b ls=%b fs=%b x=%0d fc=%0d expected az=1 ls=1 fs=1 x=0 fc=0",
                     d_az, d_ls, d_fs, d_x, d_fc);
        end
        $display("[TB] test_first_pixel done at cycle %0d", cyc);
    endtask

    task automatic test_line_timing();
        int   ls_cyc[$];
        int   hs_rise = -1, hs_fall = -1, az_cnt = 0, ls_double = 0;
        logic prev_hs, prev_ls;
        prev_hs = d_hs;
        prev_ls = d_ls;
        for (int i = 0; i < 2 * 1040 + 20; i++) begin
            tick(1'b1);
            if (d_ls) ls_cyc.push_back(cyc);
            if (d_ls && prev_ls) ls_double++;
            if (ls_cyc.size() == 1 && d_az) az_cnt++;
            if (ls_cyc.size() >= 1 && hs_rise < 0 && !prev_hs && d_hs) hs_rise = cyc;
            if (hs_rise >= 0 && hs_fall < 0 && prev_hs && !d_hs) hs_fall = cyc;
            prev_hs = d_hs;
            prev_ls = d_ls;
        end
        tests_run++;
        if (ls_cyc.size() != 2) begin
            tests_failed++;
            $display("FAIL def_line_count got %0d line_starts expected 2", ls_cyc.size());
        end
        tests_run++;
        if (ls_double != 0) begin
            tests_failed++;
            $display("FAIL def_ls_width got %0d wide pulses expected 0", ls_double);
        end
        if (ls_cyc.size() >= 2) begin
            tests_run++;
            if (ls_cyc[1] - ls_cyc[0] != 1040) begin
                tests_failed++;
                $display("FAIL def_line_period got %0d expected 1040", ls_cyc[1] - ls_cyc[0]);
            end
            tests_run++;
            if (az_cnt != 800) begin
                tests_failed++;
                $display("FAIL def_active_clocks got %0d expected 800", az_cnt);
            end
            tests_run++;
            if (hs_rise - ls_cyc[0] != 856) begin
                tests_failed++;
                $display("FAIL def_hsync_offset got %0d expected 856", hs_rise - ls_cyc[0]);
            end
            tests_run++;
            if (hs_fall - hs_rise != 120) begin
                tests_failed++;
                $display("FAIL def_hsync_width got %0d expected 120", hs_fall - hs_rise);
            end
        end
        $display("[TB] test_line_timing done at cycle %0d", cyc);
    endtask

    task automatic test_small_frame();
        int         fs_cyc[$];
        int         vs_hi = 0, y_bad = 0, off;
        logic [7:0] hs_lo_mask = '0;
        logic [31:0] x_seq = '0;
        for (int i = 0; i < 2 * 48 + 4; i++) begin
            tick(1'b1);
            if (s_fs) fs_cyc.push_back(cyc);
            if (!s_az && s_y != '0) y_bad++;
            if (fs_cyc.size() == 1) begin
                if (s_vs) vs_hi++;
                off = cyc - fs_cyc[0];
                if (off < 8) begin
                    if (!s_hs) hs_lo_mask[off] = 1'b1;
                    x_seq = {x_seq[27:0], s_x[3:0]};
                end
            end
        end
        tests_run++;
        if (fs_cyc.size() < 2) begin
            tests_failed++;
            $display("FAIL small_frame_count got %0d frame_starts expected >= 2", fs_cyc.size());
        end else begin
            tests_run++;
            if (fs_cyc[1] - fs_cyc[0] != 48) begin
                tests_failed++;
                $display("FAIL small_frame_period got %0d expected 48", fs_cyc[1] - fs_cyc[0]);
            end
        end
        tests_run++;
        if (hs_lo_mask != 8'b0110_0000) begin
            tests_failed++;
            $display("FAIL small_hsync_pixels got mask %b expected 01100000", hs_lo_mask);
        end
        tests_run++;
        if (x_seq != 32'h0123_0000) begin
            tests_failed++;
            $display("FAIL small_x_sequence got %h expected 01230000", x_seq);
        end
        tests_run++;
        if (vs_hi != 8) begin
            tests_failed++;
            $display("FAIL small_vsync_clocks got %0d expected 8", vs_hi);
        end
        tests_run++;
        if (y_bad != 0) begin
            tests_failed++;
            $display("FAIL small_y_outside got %0d nonzero cycles expected 0", y_bad);
        end
        $display("[TB] test_small_frame done at cycle %0d", cyc);
    endtask

    task automatic test_ce_toggle();
        int   ls_cyc[$];
        int   fs_cyc[$];
        int   ls_double = 0, lo_start = -1, lo_end = -1;
        logic prev_hs, prev_ls;
        prev_hs = s_hs;
        prev_ls = s_ls;
        for (int i = 0; i < 4 * 96; i++) begin
            tick((i % 2) == 0);
            if (s_ls) ls_cyc.push_back(cyc);
            if (s_fs) fs_cyc.push_back(cyc);
            if (s_ls && prev_ls) ls_double++;
            if (ls_cyc.size() >= 1 && lo_start < 0 && prev_hs && !s_hs) lo_start = cyc;
            if (lo_start >= 0 && lo_end < 0 && !prev_hs && s_hs) lo_end = cyc;
            prev_hs = s_hs;
            prev_ls = s_ls;
        end
        tests_run++;
        if (ls_double != 0) begin
            tests_failed++;
            $display("FAIL toggle_ls_width got %0d wide pulses expected 0", ls_double);
        end
        tests_run++;
        if (ls_cyc.size() < 2 || fs_cyc.size() < 2) begin
            tests_failed++;
            $display("FAIL toggle_pulse_count got ls=%0d fs=%0d expected >= 2 each", ls_cyc.size(), fs_cyc.size());
        end else begin
            tests_run++;
            if (ls_cyc[1] - ls_cyc[0] != 16) begin
                tests_failed++;
                $display("FAIL toggle_line_period got %0d expected 16", ls_cyc[1] - ls_cyc[0]);
            end
            tests_run++;
            if (fs_cyc[1] - fs_cyc[0] != 96) begin
                tests_failed++;
                $display("FAIL toggle_frame_period got %0d expected 96", fs_cyc[1] - fs_cyc[0]);
            end
            tests_run++;
            if (lo_start - ls_cyc[0] != 10) begin
                tests_failed++;
                $display("FAIL toggle_hsync_offset got %0d expected 10", lo_start - ls_cyc[0]);
            end
        end
        tests_run++;
        if (lo_end - lo_start != 4) begin
            tests_failed++;
            $display("FAIL toggle_hsync_width got %0d expected 4", lo_end - lo_start);
        end
        $display("[TB] test_ce_toggle done at cycle %0d", cyc);
    endtask

    task automatic test_reset_mid_sync();
        outs_t got, exp_v;
        apply_reset();
        repeat (870) tick(1'b1);
        tests_run++;
        if (d_hs !== 1'b1) begin
            tests_failed++;
            $display("FAIL midsync_hs_before got %b expected 1", d_hs);
        end
        // Assert reset between clock edges and look before the next edge.
        #2;
        rst = 1'b0;
        #1;
        m_def   = model_reset(1'b1, 1'b1);
        m_small = model_reset(1'b0, 1'b1);
        got   = {d_hs, d_vs, d_az, d_x, d_y, d_ls, d_fs, d_fc};
        exp_v = m_def.o;
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL midsync_async_default got {%s} expected {%s}", fmt(got), fmt(exp_v));
        end
        got   = {s_hs, s_vs, s_az, s_x, s_y, s_ls, s_fs, s_fc};
        exp_v = m_small.o;
        tests_run++;
        if (got !== exp_v) begin
            tests_failed++;
            $display("FAIL midsync_async_small got {%s} expected {%s}", fmt(got), fmt(exp_v));
        end
        pix_ce = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        tick(1'b1);
        tests_run++;
        if ({d_fs, d_x, d_hs} !== {1'b1, 11'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL midsync_restart got fs=%b x=%0d hs=%b expected fs=1 x=0 hs=0", d_fs, d_x, d_hs);
        end
        $display("[TB] test_reset_mid_sync done at cycle %0d", cyc);
    endtask

    task automatic test_frame_wrap();
        int fs_seen = 0;
        int exp_fc;
        apply_reset();
        for (int i = 0; i < 257 * 48 + 100 && fs_seen < 257; i++) begin
            tick(1'b1);
            if (s_fs) begin
                fs_seen++;
                if (fs_seen <= 3 || fs_seen >= 256) begin
                    exp_fc = (fs_seen - 1) % 256;
                    tests_run++;
                    if (int'(s_fc) != exp_fc) begin
                        tests_failed++;
                        $display("FAIL frame_count_at_fs%0d got %0d expected %0d", fs_seen, s_fc, exp_fc);
                    end
                end
            end
        end
        tests_run++;
        if (fs_seen != 257) begin
            tests_failed++;
            $display("FAIL frame_wrap_budget got %0d frame_starts expected 257", fs_seen);
        end
        $display("[TB] test_frame_wrap done at cycle %0d", cyc);
    endtask

    initial begin
        pix_ce = 1'b0;
        rst    = 1'b1;
        #1;
        rst = 1'b0;
        @(negedge clock);
        test_reset();
        test_first_pixel();
        test_line_timing();
        test_small_frame();
        test_ce_toggle();
        test_reset_mid_sync();
        test_frame_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
